// File: rtl/macro_stream_out_pkg.sv
// Shared constants, output word layout and flag encoding for the macro stream output stage.
package macro_stream_out_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAC_BITS  = 12;
   localparam int DEF_GRID_W     = 50;
   localparam int DEF_GRID_H     = 50;
   localparam int DEF_INT_SHIFT  = 4;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int OUT_W          = 40;

   localparam int FLAG_BARRIER = 0;
   localparam int FLAG_SAT     = 1;
   localparam int FLAG_RHO_NEG = 2;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] flags;
      logic [7:0] intensity;
      logic [7:0] rho_b;
   } out_word_t;

   // A barrier cell reports no saturation: its intensity is forced, not computed.
   function automatic logic [7:0] pack_flags(input logic barrier, input logic sat,
                                             input logic rho_neg);
      logic [7:0] f;
      f = '0;
      f[FLAG_BARRIER] = barrier;
      f[FLAG_SAT]     = sat & ~barrier;
      f[FLAG_RHO_NEG] = rho_neg;
      return f;
   endfunction
endpackage

// File: rtl/macro_stream_out_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is kept when a pop happens in the same cycle.
module macro_stream_out_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
   logic                         wr_en, rd_en;

   always_comb begin
      empty = (wr_q == rd_q);
      full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      rd_en = pop & ~empty;
      wr_en = push & (~full | rd_en);
      wr_d  = wr_q + (AW+1)'(wr_en);
      rd_d  = rd_q + (AW+1)'(rd_en);
      mem_d = mem_q;
      if (wr_en) mem_d[wr_q[AW-1:0]] = wdata;
      rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/macro_stream_out.sv
// Captures per-cell velocity/density, computes squared speed, quantises to an 8-bit
// intensity tagged with cell coordinates, and streams it out through a small FIFO.
module macro_stream_out
   import macro_stream_out_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int GRID_W     = DEF_GRID_W,
   parameter int GRID_H     = DEF_GRID_H,
   parameter int INT_SHIFT  = DEF_INT_SHIFT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic                  barrier,
   input  logic [DATA_WIDTH-1:0] u_x,
   input  logic [DATA_WIDTH-1:0] u_y,
   input  logic [DATA_WIDTH-1:0] rho,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      out_data,
   output logic                  frame_done,
   output logic [15:0]           frame_count,
   output logic                  overflow
);
   localparam int         SQ_W   = 2*DATA_WIDTH + 1;
   localparam logic [7:0] X_LAST = 8'(GRID_W - 1);
   localparam logic [7:0] Y_LAST = 8'(GRID_H - 1);

   typedef struct packed {
      logic                  vld;
      logic                  last;
      logic                  barrier;
      logic [7:0]            x;
      logic [7:0]            y;
      logic [DATA_WIDTH-1:0] ux;
      logic [DATA_WIDTH-1:0] uy;
      logic [7:0]            rho_b;
   } s1_t;

   typedef struct packed {
      logic            vld;
      logic            last;
      logic            barrier;
      logic [7:0]      x;
      logic [7:0]      y;
      logic [SQ_W-1:0] speed2;
      logic [7:0]      rho_b;
   } s2_t;

   typedef struct packed {
      logic      vld;
      logic      last;
      out_word_t word;
   } s3_t;

   s1_t        s1_q, s1_d;
   s2_t        s2_q, s2_d;
   s3_t        s3_q, s3_d;
   logic [7:0] x_q, x_d, y_q, y_d;
   logic       frame_done_q, frame_done_d, overflow_q, overflow_d;
   logic [15:0] frame_count_q, frame_count_d;

   logic                    accept, push, pop, fifo_full, fifo_empty, sat;
   logic [2*DATA_WIDTH-1:0] ux_e, uy_e, px, py;
   logic [SQ_W-1:0]         sq, t;

   always_comb begin
      accept = in_valid & en;
      x_d    = x_q;
      y_d    = y_q;
      s1_d.vld     = accept;
      s1_d.last    = (x_q == X_LAST) && (y_q == Y_LAST);
      s1_d.barrier = barrier;
      s1_d.x       = x_q;
      s1_d.y       = y_q;
      s1_d.ux      = u_x;
      s1_d.uy      = u_y;
      s1_d.rho_b   = rho[DATA_WIDTH-1 -: 8];
      if (accept) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 8'd1;
         end else begin
            x_d = x_q + 8'd1;
         end
      end
   end

   // Sign-extend before multiplying so the squares are exact in 2*DATA_WIDTH bits.
   always_comb begin
      ux_e = {{DATA_WIDTH{s1_q.ux[DATA_WIDTH-1]}}, s1_q.ux};
      uy_e = {{DATA_WIDTH{s1_q.uy[DATA_WIDTH-1]}}, s1_q.uy};
      px   = $signed(ux_e) * $signed(ux_e);
      py   = $signed(uy_e) * $signed(uy_e);
      sq   = {1'b0, px} + {1'b0, py};
      s2_d.vld     = s1_q.vld;
      s2_d.last    = s1_q.last;
      s2_d.barrier = s1_q.barrier;
      s2_d.x       = s1_q.x;
      s2_d.y       = s1_q.y;
      s2_d.speed2  = sq >> FRAC_BITS;
      s2_d.rho_b   = s1_q.rho_b;
   end

   always_comb begin
      t   = s2_q.speed2 >> INT_SHIFT;
      sat = |t[SQ_W-1:8];
      s3_d.vld            = s2_q.vld;
      s3_d.last           = s2_q.last;
      s3_d.word.x         = s2_q.x;
      s3_d.word.y         = s2_q.y;
      s3_d.word.flags     = pack_flags(s2_q.barrier, sat, s2_q.rho_b[7]);
      s3_d.word.intensity = s2_q.barrier ? 8'h00 : (sat ? 8'hFF : t[7:0]);
      s3_d.word.rho_b     = s2_q.rho_b[7] ? 8'h00 : s2_q.rho_b;
   end

   // Frame accounting follows the push attempt, so a dropped last cell still closes the frame.
   always_comb begin
      push          = s3_q.vld;
      pop           = out_valid & out_ready;
      frame_done_d  = s3_q.vld & s3_q.last;
      frame_count_d = frame_count_q + 16'(frame_done_d);
      overflow_d    = overflow_q | (push & fifo_full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q          <= '0;
         s2_q          <= '0;
         s3_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
      end
   end

   macro_stream_out_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (s3_q.word),
      .pop   (out_ready),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid   = ~fifo_empty;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign overflow    = overflow_q;
endmodule

// File: tb/tb_macro_stream_out.sv
// Scoreboard bench for macro_stream_out: expected words queued on each strobe, checked on pop.
module tb_macro_stream_out;
   logic        clk = 1'b0;
   logic        rst, en, in_valid, barrier, out_ready;
   logic [15:0] u_x, u_y, rho;
   logic        out_valid, frame_done, overflow;
   logic [39:0] out_data;
   logic [15:0] frame_count;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;
   int pop_cnt = 0;
   int bx = 0;
   int by = 0;
   logic [39:0] exp_q[$];

   macro_stream_out dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .barrier(barrier),
      .u_x(u_x), .u_y(u_y), .rho(rho), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .frame_done(frame_done), .frame_count(frame_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] model(input logic [15:0] ux, input logic [15:0] uy,
                                         input logic [15:0] r, input logic bar,
                                         input int x, input int y);
      longint sx, sy, sq, t;
      logic [7:0] fl, inten, rb;
      sx = longint'($signed(ux));
      sy = longint'($signed(uy));
      sq = sx*sx + sy*sy;
      t  = sq / 65536;
      inten = (t > 255) ? 8'hFF : 8'(t);
      fl = 8'h00;
      if (bar) begin
         inten = 8'h00;
         fl[0] = 1'b1;
      end else if (t > 255) begin
         fl[1] = 1'b1;
      end
      if (r[15]) begin
         fl[2] = 1'b1;
         rb = 8'h00;
      end else begin
         rb = r[15:8];
      end
      return {8'(x), 8'(y), fl, inten, rb};
   endfunction

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (!rst && out_valid && out_ready) begin
         n_tests++;
         pop_cnt++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got %h, expected no output", out_data);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL sb_data: got %h, expected %h", out_data, e);
            end
         end
      end
   end

   task automatic strobe(input logic [15:0] ux, input logic [15:0] uy, input logic [15:0] r,
                         input logic bar, input bit keep);
      in_valid = 1'b1; en = 1'b1; u_x = ux; u_y = uy; rho = r; barrier = bar;
      if (keep) exp_q.push_back(model(ux, uy, r, bar, bx, by));
      if (bx == 49) begin
         bx = 0;
         by = (by == 49) ? 0 : by + 1;
      end else begin
         bx++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; barrier = 1'b0;
   endtask

   task automatic idle(input int n, input logic iv);
      in_valid = iv; en = 1'b0;
      repeat (n) @(posedge clk);
      #1; in_valid = 1'b0; en = 1'b1;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; en = 1'b1; out_ready = 1'b0;
      exp_q.delete(); bx = 0; by = 0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({out_valid, frame_done, overflow, frame_count, out_data} !== 59'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b fd=%b ov=%b fc=%h d=%h, expected all 0",
                  out_valid, frame_done, overflow, frame_count, out_data);
      end
   endtask

   task automatic test_quantise();
      bit ok;
      strobe(16'h1000, 16'h0000, 16'h1000, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL latency_early: out_valid=%b, expected 0", out_valid);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 40'h00_00_02_FF_10) begin
         n_fail++; $display("FAIL sat_word: got v=%b %h, expected 1 000002ff10", out_valid, out_data);
      end
      #1;
      strobe(16'h0100, 16'h0000, 16'h1000, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (out_data !== 40'h00_00_02_FF_10) begin
         n_fail++; $display("FAIL head_hold: got %h, expected 000002ff10", out_data);
      end
      drain(ok);
      n_tests++;
      if (!ok || pop_cnt < 2) begin
         n_fail++; $display("FAIL quant_drain: ok=%0d pops=%0d, expected ok=1", ok, pop_cnt);
      end
   endtask

   task automatic test_frame();
      bit ok;
      do_reset();
      out_ready = 1'b1; fd_cnt = 0;
      for (int f = 1; f <= 2; f++) begin
         for (int i = 0; i < 2500; i++)
            strobe(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                   16'($urandom_range(0, 16'h7FFF)), 1'b0, 1'b1);
         drain(ok);
         n_tests++;
         if (!ok || fd_cnt != f || frame_count !== 16'(f)) begin
            n_fail++;
            $display("FAIL frame_%0d: ok=%0d frame_done=%0d count=%0d, expected 1 %0d %0d",
                     f, ok, fd_cnt, frame_count, f, f);
         end
      end
   endtask

   task automatic test_full_push_pop();
      bit ok;
      do_reset();
      for (int i = 0; i < 8; i++) strobe(16'(i * 300), 16'h0200, 16'h0400, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      strobe(16'h0800, 16'h0800, 16'h0900, 1'b0, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (overflow !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL full_pushpop: ov=%b v=%b, expected 0 1", overflow, out_valid);
      end
      pop_cnt = 0;
      drain(ok);
      n_tests++;
      if (!ok || pop_cnt != 8) begin
         n_fail++; $display("FAIL full_count: ok=%0d pops=%0d, expected 1 8", ok, pop_cnt);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      do_reset();
      for (int i = 0; i < 8; i++) strobe(16'(i * 1000), 16'(i * 77), 16'(i * 4096), 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (overflow !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL ovf_before: ov=%b v=%b, expected 0 1", overflow, out_valid);
      end
      strobe(16'h1234, 16'h0000, 16'h0100, 1'b0, 1'b0);
      strobe(16'h4321, 16'h0000, 16'h0100, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (overflow !== 1'b1 || out_data[39:24] !== 16'h0000) begin
         n_fail++; $display("FAIL ovf_after: ov=%b head_xy=%h, expected 1 0000", overflow, out_data[39:24]);
      end
      pop_cnt = 0;
      drain(ok);
      n_tests++;
      if (!ok || pop_cnt != 8 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL ovf_drain: ok=%0d pops=%0d v=%b, expected 1 8 0", ok, pop_cnt, out_valid);
      end
   endtask

   task automatic test_barrier_rho();
      bit ok;
      do_reset();
      strobe(16'h7FFF, 16'h0000, 16'h0800, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (out_data[23:8] !== 16'h0100) begin
         n_fail++; $display("FAIL barrier: flags/int=%h, expected 0100", out_data[23:8]);
      end
      drain(ok);
      out_ready = 1'b0;
      strobe(16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (out_data[23:16] !== 8'h04 || out_data[7:0] !== 8'h00) begin
         n_fail++; $display("FAIL rho_neg: flags=%h rho=%h, expected 04 00", out_data[23:16], out_data[7:0]);
      end
      drain(ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL barrier_drain: ok=%0d, expected 1", ok);
      end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      do_reset();
      out_ready = 1'b1; fd_cnt = 0;
      for (int i = 0; i < 101; i++) strobe(16'(i * 50), 16'(i * 31), 16'h1000, 1'b0, 1'b1);
      do_reset();
      n_tests++;
      if ({out_valid, overflow, frame_count, out_data} !== 58'd0) begin
         n_fail++; $display("FAIL midreset: v=%b ov=%b fc=%h d=%h, expected all 0",
                            out_valid, overflow, frame_count, out_data);
      end
      out_ready = 1'b1;
      strobe(16'h0300, 16'h0100, 16'h2000, 1'b0, 1'b1);
      idle(2, 1'b1);
      strobe(16'h0400, 16'h0000, 16'h2000, 1'b0, 1'b1);
      idle(3, 1'b0);
      strobe(16'hF000, 16'h0500, 16'h2000, 1'b0, 1'b1);
      strobe(16'h0001, 16'hFFFF, 16'h2000, 1'b0, 1'b1);
      idle(1, 1'b1);
      strobe(16'h8000, 16'h8000, 16'h2000, 1'b0, 1'b1);
      drain(ok);
      n_tests++;
      if (!ok || frame_count !== 16'd0 || fd_cnt != 0) begin
         n_fail++; $display("FAIL en_gaps: ok=%0d fc=%0d fd=%0d, expected 1 0 0", ok, frame_count, fd_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; barrier = 1'b0; out_ready = 1'b0;
      u_x = '0; u_y = '0; rho = '0;
      test_reset();
      test_quantise();
      test_frame();
      test_full_push_pop();
      test_overflow();
      test_barrier_rho();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
